// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by alu_iter and its shift step.
package alu_pkg;
    localparam int OP_W = 4;
    typedef enum logic [OP_W-1:0] {
        OP_INC  = 4'd0,
        OP_DEC  = 4'd1,
        OP_XOR  = 4'd2,
        OP_XRED = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_AND  = 4'd6,
        OP_PASS = 4'd7,
        OP_ADD  = 4'd8,
        OP_SUB  = 4'd9,
        OP_OR   = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12
    } op_e;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one-bit SHL/SHR/ROL/ROR step, returning the next value and the bit moved out.
module alu_shift_step import alu_pkg::*; #(
    parameter int DW = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [DW-1:0]   d,
    output logic [DW-1:0]   q,
    output logic            out_bit
);
    logic left, fill;
    always_comb begin
        left    = op == OP_SHL || op == OP_ROL;
        out_bit = left ? d[DW-1] : d[0];
        fill    = (op == OP_ROL || op == OP_ROR) && out_bit;
        q       = left ? {d[DW-2:0], fill} : {fill, d[DW-1:1]};
    end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU; single-cycle ops plus an iterative one-bit-per-cycle shifter.
// Define ALU_ROTATE_EN to enable ROL/ROR (opcodes 11/12); otherwise they are illegal opcodes.
module alu_iter import alu_pkg::*; #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  result,
    output logic           zero,
    output logic           carry,
    output logic           err,
    output logic           busy
);
    localparam int CW = $clog2(DW + 1);
    state_e state, state_n;
    logic [OP_W-1:0] opc, sop;
    logic [CW-1:0] cnt, amt;
    logic [DW-1:0] res_n, step_q;
    logic [DW:0] sum, diff;
    logic cy_n, err_n, is_rot, is_shift, accept, step_bit;

    assign opc = OP_W'(op);
`ifdef ALU_ROTATE_EN
    assign is_rot = opc == OP_ROL || opc == OP_ROR;
`else
    assign is_rot = 1'b0;
`endif
    assign is_shift = opc == OP_SHL || opc == OP_SHR || is_rot;
    // Shifts saturate at DW (all bits gone); rotates wrap modulo DW.
    assign amt = is_rot ? CW'(b % DW'(DW)) : (b >= DW'(DW) ? CW'(DW) : CW'(b));
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign busy      = state == SHIFT;

    always_comb begin
        res_n = a;
        cy_n  = 1'b0;
        err_n = 1'b0;
        sum   = {1'b0, a} + {1'b0, opc == OP_INC ? DW'(1) : b};
        diff  = {1'b0, a} - {1'b0, opc == OP_DEC ? DW'(1) : b};
        case (opc)
            OP_INC, OP_ADD: {cy_n, res_n} = sum;
            OP_DEC, OP_SUB: {cy_n, res_n} = diff;
            OP_XOR:         res_n = a ^ b;
            OP_XRED:        res_n = DW'(^a);
            OP_AND:         res_n = a & b;
            OP_PASS:        res_n = b;
            OP_OR:          res_n = a | b;
            OP_SHL, OP_SHR: ;
`ifdef ALU_ROTATE_EN
            OP_ROL, OP_ROR: ;
`endif
            default:        err_n = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        if (state == SHIFT) state_n = cnt == CW'(1) ? DONE : SHIFT;
        else if (accept) state_n = is_shift && amt != '0 ? SHIFT : DONE;
        else if (state == DONE && out_ready) state_n = IDLE;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else state <= state_n;
    end

    // A shift op loads a into result and then steps it in place.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            result <= '0;
            zero   <= 1'b1;
            carry  <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            sop    <= '0;
        end else if (busy) begin
            result <= step_q;
            zero   <= step_q == '0;
            carry  <= step_bit;
            cnt    <= cnt - CW'(1);
        end else if (accept) begin
            result <= res_n;
            zero   <= res_n == '0;
            carry  <= cy_n;
            err    <= err_n;
            cnt    <= amt;
            sop    <= opc;
        end
    end

    alu_shift_step #(.DW(DW)) u_step (
        .op(sop),
        .d(result),
        .q(step_q),
        .out_bit(step_bit)
    );
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the 8-bit combinational datapath ALU. Single-cycle ops retire one cycle after acceptance; shifts and rotates run on an iterative one-bit-per-cycle shifter. Results are registered alongside zero, carry and error flags. It sits between the decode/register-read stage and write-back, and stalls the issuing stage through `in_ready`.

## Interface
- `DW`, 8: operand and result width, ≥ 2
- `OPW`, 4: opcode width
- `CLK`  in  1  clock, rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `op`  in  OPW  operation code
- `a`  in  DW  operand 1
- `b`  in  DW  operand 2; shift/rotate amount for shift ops
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  operation accepted when `in_valid && in_ready`
- `out_valid`  out  1  result registers hold an unconsumed result
- `out_ready`  in  1  consumer takes the result when `out_valid && out_ready`
- `result`  out  DW  registered result
- `zero`  out  1  `result == 0`, registered with `result`
- `carry`  out  1  carry/borrow or last bit shifted out
- `err`  out  1  illegal opcode
- `busy`  out  1  high in state SHIFT

## Operation
- Opcodes:
  - 0 INC `a+1`
  - 1 DEC `a-1`
  - 2 XOR `a^b`
  - 3 XRED: `{DW-1 zeros, ^a}`
  - 4 SHL `a<<b`
  - 5 SHR `a>>b` (logical)
  - 6 AND
  - 7 PASS `b`
  - 8 ADD
  - 9 SUB `a-b`
  - 10 OR
  - 11 ROL, 12 ROR (macro-gated)
  - 13–15 illegal
- Carry:
  - INC/ADD: bit DW of the DW+1-bit sum.
  - DEC/SUB: borrow, set when `a < subtrahend`.
  - Shift/rotate: last bit moved out, or 0 if the amount is 0.
  - All other ops: 0.
- Illegal opcode: `result=a`, `err=1`, carry 0; latency is the same as a single-cycle op.
- FSM has states IDLE, SHIFT, DONE.
  - IDLE: on accept, single-cycle ops load the result and go to DONE. A shift op with effective amount n>0 loads `a` and n, then goes to SHIFT. With n=0 it goes to DONE with `result=a`.
  - SHIFT: one bit per cycle and the counter decrements. When the counter reaches 1, the final step completes and the FSM goes to DONE.
  - DONE: `out_valid=1`; `result` and flags hold until `out_ready`. On `out_ready`, a new accept loads as from IDLE; without one, go to IDLE.
- Effective shift amount:
  - SHL/SHR: `min(b, DW)`; with `b ≥ DW` the result is 0 after DW cycles.
  - ROL/ROR: `b mod DW`.
- Counter width is `$clog2(DW+1)`.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
- `zero` and `err` are captured with `result` and are never combinational from inputs.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE
  - `result=0`, `zero=1`
  - `carry=0`, `err=0`
  - `out_valid=0`, `busy=0`
- Single-cycle op: accepted at edge t, `out_valid` high after edge t+1's update, i.e. visible in cycle t+1.
- Shift by n>0: `out_valid` in cycle t+1+n.
- Back-to-back single-cycle ops with `out_ready` held high give one result per cycle.
- Reset mid-SHIFT aborts immediately. The partial result is discarded and outputs take their reset values.
- `in_valid` with `in_ready` low: inputs are ignored. The producer holds `op`, `a` and `b` stable.

## Configuration
- `ALU_ROTATE_EN` defined: opcodes 11/12 perform ROL/ROR on the iterative shifter.
- `ALU_ROTATE_EN` undefined: 11/12 are illegal (`err=1`, `result=a`, single-cycle).

## Structure
- Package `alu_pkg`:
  - `op_e` enum: opcode names and values above
  - `state_e` enum: IDLE/SHIFT/DONE
  - `OP_W` constant
- Sub-module `alu_shift_step`: combinational one-bit SHL/SHR/ROL/ROR step on DW bits, returning the next value and the bit moved out. Instantiated once in the shift datapath.

## Test plan
- DW=8, INC `a=8'hFF`, `out_ready=1` → cycle t+1: `result=0`, `zero=1`, `carry=1`, `err=0`.
- SHL `a=8'h81`, `b=3` → `busy` for 3 cycles, `out_valid` at t+4, `result=8'h08`, `carry=0`; with `b=9` → 8 cycles, `result=0`, `carry=1`.
- ROR `a=8'h01`, `b=10`, with macro → 2 cycles, `result=8'h40`; without macro → t+1, `err=1`, `result=8'h01`.
- SUB `a=3`, `b=5` with `out_ready=0` for 4 cycles → `result=8'hFE`, `carry=1` held stable, `in_ready=0` until `out_ready` rises, then the next op is accepted that same cycle.
- `Reset` asserted in SHIFT at cycle 2 of an 8-cycle shift → outputs at reset values immediately; a fresh ADD `5+7` then yields `result=12` at t+1.
- Stream of 16 random single-cycle ops with `out_ready=1` → 16 results in 16 consecutive cycles, each matching the reference model.
